// File: rtl/psram_write_buffer.sv
// Posted-write buffer in front of the PSRAM wishbone controller: writes are acked
// once queued and drained in order; reads wait until every queued write is done.
module psram_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 22
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  input  logic [3:0]              sel_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [31:0]             data_i,
  output logic                    ack_o,
  output logic [31:0]             data_o,
  output logic                    m_stb_o,
  output logic                    m_cyc_o,
  output logic [3:0]              m_sel_o,
  output logic                    m_we_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic [31:0]             m_data_o,
  input  logic                    m_ack_i,
  input  logic [31:0]             m_data_i,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + 36;

  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_GAP} mstate_t;

  mstate_t         state, state_nxt;
  logic [EW-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic            ack_r, cur_rd, rd_abort;
  logic            req, push, pop, load_rd, load_wr, rd_done;

  // A request is new only while the previous ack is not still being presented.
  assign req   = stb_i & cyc_i & ~ack_r;
  assign push  = req & we_i & (count < CW'(DEPTH));
  assign head  = fifo_mem[rd_ptr];

  assign ack_o   = ack_r & stb_i;
  assign m_stb_o = (state == M_BUSY);
  assign m_cyc_o = (state == M_BUSY);
  assign count_o = count;
  assign empty_o = (count == '0) && (state == M_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= M_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_rd   = 1'b0;
    load_wr   = 1'b0;
    pop       = 1'b0;
    rd_done   = 1'b0;
    case (state)
      M_IDLE: begin
        // Read eligibility needs an empty FIFO, so reads never overtake writes.
        if (req && !we_i && count == '0) begin
          load_rd   = 1'b1;
          state_nxt = M_BUSY;
        end else if (count != '0) begin
          load_wr   = 1'b1;
          state_nxt = M_BUSY;
        end
      end
      M_BUSY: begin
        if (m_ack_i) begin
          state_nxt = M_GAP;
          pop       = ~cur_rd;
          rd_done   = cur_rd & ~rd_abort & stb_i & cyc_i;
        end
      end
      M_GAP:   state_nxt = M_IDLE;
      default: state_nxt = M_IDLE;
    endcase
  end

  // Queue storage carries no reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= {addr_i, sel_i, data_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_we_o   <= 1'b0;
      m_sel_o  <= '0;
      m_addr_o <= '0;
      m_data_o <= '0;
      cur_rd   <= 1'b0;
      rd_abort <= 1'b0;
      data_o   <= '0;
      ack_r    <= 1'b0;
    end else begin
      if (load_rd) begin
        m_we_o   <= 1'b0;
        m_sel_o  <= sel_i;
        m_addr_o <= addr_i;
        m_data_o <= '0;
        cur_rd   <= 1'b1;
        rd_abort <= 1'b0;
      end else if (load_wr) begin
        m_we_o                         <= 1'b1;
        {m_addr_o, m_sel_o, m_data_o}  <= head;
        cur_rd                         <= 1'b0;
        rd_abort                       <= 1'b0;
      end else if (state == M_BUSY && cur_rd && !(stb_i && cyc_i)) begin
        // The PSRAM access cannot be aborted; remember to discard its data.
        rd_abort <= 1'b1;
      end
      if (rd_done) data_o <= m_data_i;
      if (!stb_i)                ack_r <= 1'b0;
      else if (push || rd_done)  ack_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psram_write_buffer.sv
// Directed bench for psram_write_buffer with a latency-programmable PSRAM slave model.
module tb_psram_write_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stb_i, cyc_i, we_i;
  logic [3:0]  sel_i;
  logic [21:0] addr_i;
  logic [31:0] data_i;
  logic        ack_o;
  logic [31:0] data_o;
  logic        m_stb_o, m_cyc_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [21:0] m_addr_o;
  logic [31:0] m_data_o;
  logic        m_ack_i = 1'b0;
  logic [31:0] m_data_i = '0;
  logic        empty_o;
  logic [2:0]  count_o;

  int n_assert = 0;
  int n_fail   = 0;

  int slave_lat = 4;
  logic slave_en = 1'b1;
  int wcnt = 0;
  logic [31:0] smem [logic [21:0]];
  logic [21:0] lg_addr [$];
  logic [3:0]  lg_sel  [$];
  logic [31:0] lg_data [$];
  logic        lg_we   [$];

  psram_write_buffer #(.DEPTH(4), .ADDR_WIDTH(22)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stb_i(stb_i), .cyc_i(cyc_i), .sel_i(sel_i),
    .we_i(we_i), .addr_i(addr_i), .data_i(data_i), .ack_o(ack_o), .data_o(data_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_sel_o(m_sel_o), .m_we_o(m_we_o),
    .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_ack_i(m_ack_i), .m_data_i(m_data_i),
    .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave: acks after slave_lat negedges of strobe; the cycle after an ack must show strobe low.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_ack_i = 1'b0;
      wcnt = 0;
    end else if (m_ack_i) begin
      check("gap_after_ack", 64'(m_stb_o), 64'd0);
      m_ack_i = 1'b0;
      wcnt = 0;
    end else if (m_stb_o && slave_en) begin
      wcnt++;
      if (wcnt >= slave_lat) begin
        lg_addr.push_back(m_addr_o);
        lg_sel.push_back(m_sel_o);
        lg_data.push_back(m_data_o);
        lg_we.push_back(m_we_o);
        if (m_we_o) begin
          logic [31:0] old;
          old = smem.exists(m_addr_o) ? smem[m_addr_o] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (m_sel_o[b]) old[8*b +: 8] = m_data_o[8*b +: 8];
          smem[m_addr_o] = old;
        end else begin
          m_data_i = smem.exists(m_addr_o) ? smem[m_addr_o] : 32'h0;
        end
        m_ack_i = 1'b1;
      end
    end
  end

  task automatic clear_log();
    lg_addr.delete(); lg_sel.delete(); lg_data.delete(); lg_we.delete();
  endtask

  task automatic wb_write(input logic [21:0] a, input logic [3:0] s, input logic [31:0] d,
                          output int lat);
    addr_i = a; sel_i = s; data_i = d; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk_i); #1; lat++;
    end while (!ack_o && lat < 300);
    check("wr_ack", 64'(ack_o), 64'd1);
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic wb_read(input logic [21:0] a, input logic [3:0] s, output logic [31:0] d);
    int n;
    addr_i = a; sel_i = s; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk_i); #1; n++;
    end while (!ack_o && n < 300);
    check("rd_ack", 64'(ack_o), 64'd1);
    d = data_o;
    stb_i = 1'b0; cyc_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!empty_o && n < 400) begin
      @(posedge clk_i); #1; n++;
    end
    check(tag, 64'(empty_o), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] rd;
    logic held, saw_ack;
    int n;

    rst_ni = 1'b0; stb_i = 0; cyc_i = 0; we_i = 0; sel_i = 0; addr_i = 0; data_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", 64'(ack_o), 64'd0);
    check("rst_data_o", 64'(data_o), 64'd0);
    check("rst_mstb", 64'({m_stb_o, m_cyc_o, m_we_o}), 64'd0);
    check("rst_msel", 64'(m_sel_o), 64'd0);
    check("rst_maddr", 64'(m_addr_o), 64'd0);
    check("rst_mdata", 64'(m_data_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single write then read back
    slave_lat = 4; clear_log();
    wb_write(22'h000010, 4'hF, 32'hDEADBEEF, lat);
    check("t1_wr_lat", 64'(lat), 64'd1);
    wb_read(22'h000010, 4'hF, rd);
    check("t1_rd_data", 64'(rd), 64'hDEADBEEF);
    check("t1_data_o", 64'(data_o), 64'hDEADBEEF);
    check("t1_log_n", 64'(lg_we.size()), 64'd2);
    if (lg_we.size() == 2) begin
      check("t1_first_is_wr", 64'({lg_we[0], lg_addr[0], lg_data[0]}), {1'b1, 22'h10, 32'hDEADBEEF});
      check("t1_then_rd", 64'({lg_we[1], lg_addr[1]}), 64'({1'b0, 22'h10}));
    end
    wait_empty("t1_empty");

    // Fill to full with the slave stalled, then let the fifth write in
    clear_log(); slave_en = 1'b0; slave_lat = 4;
    for (int i = 0; i < 4; i++) begin
      wb_write(22'(i), 4'hF, 32'h11111111 * (i + 1), lat);
      check("t2_wr_lat", 64'(lat), 64'd1);
    end
    check("t2_count_full", 64'(count_o), 64'd4);
    check("t2_mstb_busy", 64'(m_stb_o), 64'd1);
    check("t2_maddr_head", 64'(m_addr_o), 64'd0);
    addr_i = 22'd4; sel_i = 4'hF; data_i = 32'h55555555; we_i = 1; cyc_i = 1; stb_i = 1;
    held = 1'b0;
    repeat (6) begin
      @(posedge clk_i); #1;
      held = held | ack_o;
    end
    check("t2_fifth_held", 64'(held), 64'd0);
    check("t2_count_held", 64'(count_o), 64'd4);
    slave_en = 1'b1;
    n = 0;
    while (!ack_o && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    check("t2_fifth_ack", 64'(ack_o), 64'd1);
    check("t2_fifth_wait", 64'(n >= 4), 64'd1);
    check("t2_count_after", 64'(count_o), 64'd4);
    stb_i = 0; cyc_i = 0; we_i = 0;
    @(posedge clk_i); #1;
    wait_empty("t2_empty");
    check("t2_log_n", 64'(lg_addr.size()), 64'd5);
    if (lg_addr.size() == 5)
      for (int i = 0; i < 5; i++) begin
        check("t2_order_addr", 64'(lg_addr[i]), 64'(i));
        check("t2_order_data", 64'(lg_data[i]), 64'(32'h11111111 * (i + 1)));
      end

    // Partial-width write
    clear_log(); slave_lat = 2;
    wb_write(22'h3FFFFF, 4'b0011, 32'h0000ABCD, lat);
    wait_empty("t3_empty");
    check("t3_log_n", 64'(lg_addr.size()), 64'd1);
    if (lg_addr.size() == 1)
      check("t3_fields", 64'({lg_we[0], lg_sel[0], lg_addr[0], lg_data[0]}),
            64'({1'b1, 4'b0011, 22'h3FFFFF, 32'h0000ABCD}));

    // Sixteen queued writes: gap checks, pointer wrap, count returns to 0
    clear_log(); slave_lat = 1;
    for (int i = 0; i < 16; i++)
      wb_write(22'(32'h100 + i), 4'hF, 32'hA0000000 + i, lat);
    wait_empty("t4_empty");
    check("t4_count", 64'(count_o), 64'd0);
    check("t4_log_n", 64'(lg_addr.size()), 64'd16);
    if (lg_addr.size() == 16) begin
      check("t4_last_addr", 64'(lg_addr[15]), 64'h10F);
      check("t4_last_data", 64'(lg_data[15]), 64'hA000000F);
    end

    // Aborted read keeps data_o; a following read returns correct data
    wb_write(22'h000020, 4'hF, 32'h12345678, lat);
    wait_empty("t5_pre_empty");
    clear_log(); slave_lat = 4;
    addr_i = 22'h000020; sel_i = 4'hF; we_i = 0; cyc_i = 1; stb_i = 1;
    n = 0;
    while (!m_stb_o && n < 50) begin
      @(posedge clk_i); #1; n++;
    end
    check("t5_rd_issued", 64'({m_stb_o, m_we_o}), 64'b10);
    cyc_i = 0; stb_i = 0;
    saw_ack = 1'b0;
    repeat (12) begin
      @(posedge clk_i); #1;
      saw_ack = saw_ack | ack_o;
    end
    check("t5_no_ack", 64'(saw_ack), 64'd0);
    check("t5_empty", 64'(empty_o), 64'd1);
    check("t5_data_kept", 64'(data_o), 64'hDEADBEEF);
    check("t5_master_done", 64'(lg_we.size()), 64'd1);
    wb_read(22'h000020, 4'hF, rd);
    check("t5_reread", 64'(rd), 64'h12345678);

    // Asynchronous reset in the middle of a drain
    clear_log(); slave_en = 1'b0;
    for (int i = 0; i < 3; i++)
      wb_write(22'(32'h200 + i), 4'hF, 32'hC0 + i, lat);
    check("t6_pre_count", 64'(count_o), 64'd3);
    check("t6_pre_mstb", 64'(m_stb_o), 64'd1);
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1;
    check("t6_mstb_async", 64'({m_stb_o, m_cyc_o}), 64'd0);
    check("t6_count_async", 64'(count_o), 64'd0);
    check("t6_data_o_async", 64'(data_o), 64'd0);
    check("t6_maddr_async", 64'(m_addr_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #3;
    rst_ni = 1'b1; slave_en = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    check("t6_empty", 64'(empty_o), 64'd1);
    check("t6_no_stale", 64'(lg_addr.size()), 64'd0);
    check("t6_mstb_idle", 64'(m_stb_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
